// File: rtl/uart16550_pkg.sv
// Shared UART16550 register layouts and interrupt identifiers.
// Used by the interrupt controller and its receiver-timeout counter.
package uart16550_pkg;

    localparam int TIMEOUT_CHARS_DEF = 4;

    typedef struct packed {
        logic [3:0] rsvd;
        logic       edssi;
        logic       elsi;
        logic       etbei;
        logic       erbfi;
    } ier_t;

    typedef struct packed {
        logic       dlab;
        logic       bc;
        logic       sp;
        logic       eps;
        logic       pen;
        logic       stb;
        logic [1:0] wls;
    } lcr_t;

    typedef enum logic [2:0] {
        IID_MS   = 3'b000,
        IID_THRE = 3'b001,
        IID_RDA  = 3'b010,
        IID_RLS  = 3'b011,
        IID_CTI  = 3'b110
    } intid_t;

    typedef struct packed {
        logic [1:0] fifos_enabled;
        logic [1:0] zeros;
        intid_t     interrupt_id;
        logic       interrupt_pending;
    } iir_t;

    localparam logic [7:0] IIR_NONE = 8'h01;

endpackage

// File: rtl/uart16550_rx_timeout.sv
// Receiver character-timeout: frame length from LCR, limit multiply,
// saturating idle counter and the sticky timeout flag.
module uart16550_rx_timeout
    import uart16550_pkg::*;
#(
    parameter int TIMEOUT_CHARS = TIMEOUT_CHARS_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] wls_i,
    input  logic       pen_i,
    input  logic       stb_i,
    input  logic       fifo_ena_i,
    input  logic       tick_i,
    input  logic       rx_nempty_i,
    input  logic       rx_push_i,
    input  logic       rx_pop_i,
    output logic       timeout_o
);

    localparam logic [9:0] CNT_MAX = 10'h3FF;

    logic [3:0]  bits;
    logic [15:0] limit;
    logic [9:0]  cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic        hit;

    // 1.5 stop bits is counted as 2 so the frame is always a whole number of bits
    assign bits  = 4'd6 + {2'b00, wls_i} + {3'b000, pen_i} + (stb_i ? 4'd2 : 4'd1);
    assign limit = 16'(TIMEOUT_CHARS) * 16'd16 * {12'd0, bits};
    // >= rather than == so a shortened frame mid-count still fires on the next tick
    assign hit   = tick_i && ({6'd0, cnt_q} >= (limit - 16'd1));

    always_comb begin
        cnt_d = cnt_q;
        if (rx_push_i || rx_pop_i || !rx_nempty_i || !fifo_ena_i)
            cnt_d = '0;
        else if (tick_i && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 10'd1;

        timeout_d = timeout_q;
        if (rx_push_i || rx_pop_i || !fifo_ena_i)
            timeout_d = 1'b0;
        else if (hit)
            timeout_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/uart16550_intctrl.sv
// UART16550 interrupt controller: THRE-pending latch, five-source
// priority encoder and the registered IIR / irq outputs.
module uart16550_intctrl
    import uart16550_pkg::*;
#(
    parameter int TIMEOUT_CHARS = TIMEOUT_CHARS_DEF
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [7:0] ier_i,
    input  logic       fifo_ena_i,
    input  logic [7:0] lcr_i,
    input  logic       baud16_tick_i,
    input  logic       lsr_err_i,
    input  logic       rx_trig_i,
    input  logic       rx_nempty_i,
    input  logic       rx_push_i,
    input  logic       rx_pop_i,
    input  logic       thre_i,
    input  logic       thr_wr_i,
    input  logic       iir_rd_i,
    input  logic       msr_delta_i,
    output logic [7:0] iir_o,
    output logic       irq_o
);

    ier_t   ier;
    lcr_t   lcr;
    iir_t   iir_q, iir_d;
    logic   irq_q, irq_d;
    logic   thre_q, etbei_q;
    logic   thre_pend_q, thre_pend_d;
    logic   timeout_q;
    logic   thre_set, thre_iir_clr;
    logic   any_src;
    intid_t id;
    logic   cfg_unused;

    assign ier = ier_t'(ier_i);
    assign lcr = lcr_t'(lcr_i);
    assign cfg_unused = ^{ier.rsvd, lcr.dlab, lcr.bc, lcr.sp, lcr.eps};

    uart16550_rx_timeout #(
        .TIMEOUT_CHARS(TIMEOUT_CHARS)
    ) u_rx_timeout (
        .clk_i       (PCLK),
        .rst_i       (PRESET),
        .wls_i       (lcr.wls),
        .pen_i       (lcr.pen),
        .stb_i       (lcr.stb),
        .fifo_ena_i  (fifo_ena_i),
        .tick_i      (baud16_tick_i),
        .rx_nempty_i (rx_nempty_i),
        .rx_push_i   (rx_push_i),
        .rx_pop_i    (rx_pop_i),
        .timeout_o   (timeout_q)
    );

    // Reading the IIR only acknowledges THRE if THRE is what that read returned
    assign thre_set     = (thre_i && !thre_q) || (ier.etbei && !etbei_q && thre_i);
    assign thre_iir_clr = iir_rd_i && (iir_q.interrupt_id == IID_THRE) && !iir_q.interrupt_pending;

    always_comb begin
        thre_pend_d = thre_pend_q;
        if (thr_wr_i)
            thre_pend_d = 1'b0;
        else if (thre_set)
            thre_pend_d = 1'b1;
        else if (thre_iir_clr)
            thre_pend_d = 1'b0;

        any_src = 1'b1;
        id      = IID_MS;
        if (ier.elsi && lsr_err_i)
            id = IID_RLS;
        else if (ier.erbfi && rx_trig_i)
            id = IID_RDA;
        else if (ier.erbfi && timeout_q)
            id = IID_CTI;
        else if (ier.etbei && thre_pend_q)
            id = IID_THRE;
        else if (ier.edssi && msr_delta_i)
            id = IID_MS;
        else
            any_src = 1'b0;

        iir_d = '{fifos_enabled: {2{fifo_ena_i}}, zeros: 2'b00,
                  interrupt_id: id, interrupt_pending: !any_src};
        irq_d = any_src;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            thre_q      <= 1'b0;
            etbei_q     <= 1'b0;
            thre_pend_q <= 1'b0;
            iir_q       <= iir_t'(IIR_NONE);
            irq_q       <= 1'b0;
        end else begin
            thre_q      <= thre_i;
            etbei_q     <= ier.etbei;
            thre_pend_q <= thre_pend_d;
            iir_q       <= iir_d;
            irq_q       <= irq_d;
        end
    end

    assign iir_o = iir_q;
    assign irq_o = irq_q;

endmodule
